mem_dispatch_arbiter: RTL

MEM_DISPATCH_ARBITER -- requirements
Module: mem_dispatch_arbiter

---
 rtl/mem_dispatch_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_dispatch_arbiter.sv
// Store/load dispatch arbiter in front of a single-ported d-cache.
// Optional load starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_dispatch_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_WIDTH    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [IDX_WIDTH-1:0]  st_idx,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [IDX_WIDTH-1:0]  ld_idx,
  input  logic                  flush,
  input  logic                  dc_miss,
  input  logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_valid,
  output logic                  dc_action,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  st_ack,
  output logic                  ld_ack,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [IDX_WIDTH-1:0]  ld_idx_out,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] MISS = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  hold_wr;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic [IDX_WIDTH-1:0]  hold_idx;
  logic                  squash;
  logic                  active;
  logic                  done;
  logic                  grant_st;
  logic                  grant_ld;
  logic                  force_ld;

  assign active = (state == REQ) || (state == MISS);
  assign done   = active && !dc_miss;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign force_ld = ld_valid && !flush &&
                    (starve_cnt == STARVE_MAX);

  // Counts stores that jumped ahead of a waiting load; saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_ld) begin
      starve_cnt <= '0;
    end else if (grant_st && ld_valid &&
                 starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign force_ld = 1'b0;
`endif

  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (state == IDLE) begin
      if (force_ld) begin
        grant_ld = 1'b1;
      end else if (st_valid) begin
        grant_st = 1'b1;
      end else if (ld_valid && !flush) begin
        grant_ld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_st || grant_ld) begin
          state_nxt = REQ;
        end
      end
      REQ, MISS: begin
        state_nxt = dc_miss ? MISS : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_wr    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_idx   <= '0;
    end else if (grant_st) begin
      hold_wr    <= 1'b1;
      hold_addr  <= st_addr;
      hold_wdata <= st_data;
      hold_idx   <= st_idx;
    end else if (grant_ld) begin
      hold_wr    <= 1'b0;
      hold_addr  <= ld_addr;
      hold_wdata <= '0;
      hold_idx   <= ld_idx;
    end
  end

  // A flushed load still finishes at the cache but never acks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      squash <= 1'b0;
    end else if (grant_st || grant_ld) begin
      squash <= 1'b0;
    end else if (active && !hold_wr && flush) begin
      squash <= 1'b1;
    end
  end

  assign busy       = active;
  assign dc_valid   = active;
  assign dc_action  = active && hold_wr;
  assign dc_addr    = active ? hold_addr : '0;
  assign dc_wdata   = active ? hold_wdata : '0;
  assign st_ack     = done && hold_wr && rst_n;
  assign ld_ack     = done && !hold_wr && !squash &&
                      !flush && rst_n;
  assign ld_data    = ld_ack ? dc_rdata : '0;
  assign ld_idx_out = ld_ack ? hold_idx : '0;

endmodule
